// File: rtl/mp_add_ctrl_pkg.sv
// Shared definitions for the multi-precision add sequencer: word width,
// FSM state encoding and a word-slice helper for packed operands.
package mp_add_pkg;

   localparam int WORD_W    = 64;
   localparam int MAX_WORDS = 16;
   localparam int MAX_OP_W  = WORD_W * MAX_WORDS;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } mp_state_t;

   // Return word i (bits [64i+63:64i]) of an operand zero-extended to the
   // widest legal size, so one helper serves every WORDS setting.
   function automatic logic [WORD_W-1:0] get_word(input logic [MAX_OP_W-1:0] op,
                                                  input int                  i);
      return op[i*WORD_W +: WORD_W];
   endfunction

endpackage

// File: rtl/mp_add_ctrl_if.sv
// Operand-side and result-side handshake bundle for mp_add_ctrl.
// slave is the sequencer's view; master is the producer/consumer view.
interface mp_add_ctrl_if #(
   parameter int WORDS = 4
) ();

   logic                                 in_valid;
   logic                                 in_ready;
   logic [WORDS*mp_add_pkg::WORD_W-1:0]  in_a;
   logic [WORDS*mp_add_pkg::WORD_W-1:0]  in_b;
   logic                                 in_cin;
   logic                                 out_valid;
   logic                                 out_ready;
   logic [WORDS*mp_add_pkg::WORD_W-1:0]  out_sum;
   logic                                 out_cout;
   logic                                 busy;

   modport slave (
      input  in_valid, in_a, in_b, in_cin, out_ready,
      output in_ready, out_valid, out_sum, out_cout, busy
   );

   modport master (
      output in_valid, in_a, in_b, in_cin, out_ready,
      input  in_ready, out_valid, out_sum, out_cout, busy
   );

endinterface

// File: rtl/mp_add_ctrl_adder_64.sv
// One 64-bit ripple-carry adder slice; purely combinational.
module adder_64
   import mp_add_pkg::*;
(
   input  logic [WORD_W-1:0] in1,
   input  logic [WORD_W-1:0] in2,
   input  logic              cin,
   output logic [WORD_W-1:0] sum,
   output logic              cout
);

   // Widen by one bit so the top bit of the result is the carry out.
   always_comb begin
      {cout, sum} = {1'b0, in1} + {1'b0, in2} + {{WORD_W{1'b0}}, cin};
   end

endmodule

// File: rtl/mp_add_ctrl.sv
// Multi-precision add sequencer: adds two WORDS x 64-bit operands through a
// single 64-bit adder slice, one word per cycle, LS word first, with the
// carry chained through carry_q. Result is held in HOLD until accepted.
module mp_add_ctrl
   import mp_add_pkg::*;
#(
   parameter int WORDS = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   mp_add_ctrl_if.slave  bus
);

   localparam int OP_W  = WORDS * WORD_W;
   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   mp_state_t         state;
   logic [IDX_W-1:0]  idx;
   logic              carry_q;
   logic [OP_W-1:0]   a_q;
   logic [OP_W-1:0]   b_q;
   logic [OP_W-1:0]   sum_q;
   logic [OP_W-1:0]   sum_next;

   logic [WORD_W-1:0] word_a;
   logic [WORD_W-1:0] word_b;
   logic [WORD_W-1:0] word_sum;
   logic              word_cout;

   // Select the operand words addressed by the running word counter.
   always_comb begin
      word_a = get_word(MAX_OP_W'(a_q), int'(idx));
      word_b = get_word(MAX_OP_W'(b_q), int'(idx));
   end

   adder_64 u_adder (
      .in1  (word_a),
      .in2  (word_b),
      .cin  (carry_q),
      .sum  (word_sum),
      .cout (word_cout)
   );

   // Accumulated sum with the current word merged in; becomes the visible
   // result on the last RUN edge so out_sum never shows partial results.
   always_comb begin
      sum_next = sum_q;
      sum_next[int'(idx)*WORD_W +: WORD_W] = word_sum;
   end

   // Control FSM with registered handshake outputs plus the word datapath.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         idx           <= '0;
         carry_q       <= 1'b0;
         a_q           <= '0;
         b_q           <= '0;
         sum_q         <= '0;
         bus.out_sum   <= '0;
         bus.out_cout  <= 1'b0;
         bus.in_ready  <= 1'b1;
         bus.out_valid <= 1'b0;
         bus.busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid && bus.in_ready) begin
                  a_q          <= bus.in_a;
                  b_q          <= bus.in_b;
                  carry_q      <= bus.in_cin;
                  idx          <= '0;
                  state        <= RUN;
                  bus.in_ready <= 1'b0;
                  bus.busy     <= 1'b1;
               end
            end
            RUN: begin
               sum_q   <= sum_next;
               carry_q <= word_cout;
               if (idx == LAST_IDX) begin
                  bus.out_sum   <= sum_next;
                  bus.out_cout  <= word_cout;
                  bus.out_valid <= 1'b1;
                  bus.busy      <= 1'b0;
                  idx           <= '0;
                  state         <= HOLD;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            HOLD: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  bus.in_ready  <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: begin
               state         <= IDLE;
               bus.in_ready  <= 1'b1;
               bus.out_valid <= 1'b0;
               bus.busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mp_add_ctrl.sv
// Directed and randomised bench for mp_add_ctrl with WORDS=4.
module tb_mp_add_ctrl;

   localparam int WORDS = 4;
   localparam int OW    = WORDS * 64;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   mp_add_ctrl_if #(.WORDS(WORDS)) bus ();

   mp_add_ctrl #(.WORDS(WORDS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic [OW-1:0] a;
      logic [OW-1:0] b;
      logic          cin;
      logic [OW-1:0] s;
      logic          co;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [OW:0] act, input logic [OW:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present an operand set and return #1 after the accept edge.
   task automatic start_op(input logic [OW-1:0] a, input logic [OW-1:0] b, input logic cin);
      int n;
      n = 0;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_cin   = cin;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && n < 50) begin
         step();
         n++;
      end
      if (n >= 50) chk("accept_timeout", 1, 0);
      step();
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!bus.out_valid && lat < 50) begin
         step();
         lat++;
      end
      if (lat >= 50) chk("valid_timeout", 1, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int            lat;
      int            cnt;
      int            stall;
      logic          r;
      logic [OW-1:0] ra, rb;
      logic          rc;
      logic [OW:0]   ref_sum;

      vecs[0] = '{'1, '0, 1'b1, '0, 1'b1};
      vecs[1] = '{256'd1, 256'd1, 1'b0, 256'd2, 1'b0};
      vecs[2] = '{256'h0000000000000000_0000000000000000_0000000000000000_FFFFFFFFFFFFFFFF,
                  256'd1, 1'b0,
                  256'h0000000000000000_0000000000000000_0000000000000001_0000000000000000, 1'b0};
      vecs[3] = '{'1, '1, 1'b1, '1, 1'b1};
      vecs[4] = '{'0, '0, 1'b1, 256'd1, 1'b0};
      vecs[5] = '{256'h8000000000000000_0000000000000000_0000000000000000_0000000000000000,
                  256'h8000000000000000_0000000000000000_0000000000000000_0000000000000000,
                  1'b0, '0, 1'b1};
      vecs[6] = '{256'h0000000000000000_0000000000000000_FFFFFFFFFFFFFFFF_0000000000000000,
                  256'h0000000000000000_0000000000000000_0000000000000001_0000000000000000,
                  1'b0,
                  256'h0000000000000000_0000000000000001_0000000000000000_0000000000000000, 1'b0};
      vecs[7] = '{256'd10, 256'd20, 1'b1, 256'h1F, 1'b0};

      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_cin    = 1'b0;
      bus.out_ready = 1'b1;

      // reset state
      repeat (3) step();
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_out_sum", bus.out_sum, 0);
      chk("rst_out_cout", bus.out_cout, 0);
      rst_n = 1'b1;
      step();

      // table-driven vectors
      for (int i = 0; i < 8; i++) begin
         bus.out_ready = 1'b1;
         start_op(vecs[i].a, vecs[i].b, vecs[i].cin);
         chk($sformatf("v%0d_busy", i), bus.busy, 1);
         chk($sformatf("v%0d_in_ready_low", i), bus.in_ready, 0);
         wait_valid(lat);
         chk($sformatf("v%0d_latency", i), lat, 4);
         chk($sformatf("v%0d_sum", i), bus.out_sum, vecs[i].s);
         chk($sformatf("v%0d_cout", i), bus.out_cout, vecs[i].co);
         step();
         chk($sformatf("v%0d_drain_valid", i), bus.out_valid, 0);
         chk($sformatf("v%0d_drain_ready", i), bus.in_ready, 1);
      end

      // backpressure: HOLD for 10 cycles
      bus.out_ready = 1'b0;
      start_op(256'd3, 256'd4, 1'b0);
      wait_valid(lat);
      for (int i = 0; i < 10; i++) begin
         chk("bp_valid", bus.out_valid, 1);
         chk("bp_in_ready", bus.in_ready, 0);
         chk("bp_sum", bus.out_sum, 256'd7);
         chk("bp_cout", bus.out_cout, 0);
         step();
      end
      bus.out_ready = 1'b1;
      step();
      chk("bp_release_valid", bus.out_valid, 0);
      chk("bp_release_ready", bus.in_ready, 1);

      // in_valid during RUN is ignored
      start_op(256'd100, 256'd200, 1'b0);
      bus.in_a     = 256'd5;
      bus.in_b     = 256'd5;
      bus.in_cin   = 1'b1;
      bus.in_valid = 1'b1;
      chk("ign_in_ready0", bus.in_ready, 0);
      step();
      chk("ign_in_ready1", bus.in_ready, 0);
      step();
      bus.in_valid = 1'b0;
      wait_valid(lat);
      chk("ign_sum", bus.out_sum, 256'd300);
      chk("ign_cout", bus.out_cout, 0);
      step();
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus.out_valid) cnt++;
         step();
      end
      chk("ign_no_second_result", cnt, 0);

      // reset mid-RUN at idx==2
      start_op('1, 256'd1, 1'b0);
      step();
      step();
      chk("mid_busy_before_rst", bus.busy, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", bus.out_valid, 0);
      chk("mid_rst_in_ready", bus.in_ready, 1);
      chk("mid_rst_sum", bus.out_sum, 0);
      chk("mid_rst_busy", bus.busy, 0);
      step();
      step();
      rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (bus.out_valid) cnt++;
      end
      chk("mid_rst_no_result", cnt, 0);
      start_op(256'd5, 256'd7, 1'b0);
      wait_valid(lat);
      chk("post_rst_latency", lat, 4);
      chk("post_rst_sum", bus.out_sum, 256'd12);
      chk("post_rst_cout", bus.out_cout, 0);
      step();

      // random back-to-back ops with consumer stalls
      for (int k = 0; k < 1000; k++) begin
         for (int w = 0; w < 8; w++) begin
            ra[w*32 +: 32] = $urandom;
            rb[w*32 +: 32] = $urandom;
         end
         for (int w = 0; w < WORDS; w++) begin
            if ($urandom_range(0, 3) == 0) ra[w*64 +: 64] = '1;
            if ($urandom_range(0, 7) == 0) rb[w*64 +: 64] = '0;
         end
         rc = 1'($urandom_range(0, 1));
         ref_sum = {1'b0, ra} + {1'b0, rb} + {{OW{1'b0}}, rc};
         start_op(ra, rb, rc);
         wait_valid(lat);
         chk("rand_result", {bus.out_cout, bus.out_sum}, ref_sum);
         stall = 0;
         do begin
            r = 1'($urandom_range(0, 1));
            bus.out_ready = r;
            step();
            stall++;
         end while (!r && stall < 50);
      end
      bus.out_ready = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
